// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four hex digits onto a common-anode
// 4-digit display (active-low seg/dig). Each digit slot starts with a short
// all-off guard to prevent ghosting, then drives the digit for the rest of the
// slot. Inputs are double-buffered (pending -> active at frame wrap) so a frame
// never mixes old and new values.
// Optional feature macro: LEADING_ZERO_BLANK_EN (auto-blank leading zeros of
// digits 0..2 when the active buffer is latched).
module seven_seg_scanner #(
  parameter logic [31:0] SCAN_DIV     = 32'd12500,
  parameter logic [31:0] BLANK_CYCLES = 32'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blank_mask,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_done
);

  typedef enum logic {PH_BLANK, PH_ON} phase_t;

  logic [31:0] r_cnt;
  logic [1:0]  r_slot;
  logic [15:0] r_pend_digits;
  logic [3:0]  r_pend_dp;
  logic [3:0]  r_pend_blank;
  logic [15:0] r_act_digits;
  logic [3:0]  r_act_dp;
  logic [3:0]  r_act_blank;
  logic [7:0]  r_seg;
  logic [3:0]  r_dig;
  logic        r_frame_done;

  phase_t      w_phase;
  logic        w_last_cnt;
  logic        w_wrap;
  logic [15:0] w_src_digits;
  logic [3:0]  w_src_dp;
  logic [3:0]  w_src_blank;
  logic [3:0]  w_auto_blank;
  logic [3:0]  w_cur_val;
  logic        w_cur_dp;
  logic        w_cur_blank;
  logic [7:0]  w_seg_nxt;
  logic [3:0]  w_dig_nxt;

  // Hex to segments g..a, active-low, decimal point not included.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h58;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign w_phase    = (r_cnt < BLANK_CYCLES) ? PH_BLANK : PH_ON;
  assign w_last_cnt = (r_cnt == SCAN_DIV - 32'd1);
  assign w_wrap     = w_last_cnt && (r_slot == 2'd3);

  // A load on the wrap cycle bypasses pending so it shows in the very next frame.
  assign w_src_digits = load ? digits     : r_pend_digits;
  assign w_src_dp     = load ? dp_mask    : r_pend_dp;
  assign w_src_blank  = load ? blank_mask : r_pend_blank;

`ifdef LEADING_ZERO_BLANK_EN
  // Suppression runs left to right and stops at the first nonzero digit or
  // the first digit with its decimal point lit; digit3 always shows.
  logic w_z0, w_z1, w_z2;
  assign w_z0 = (w_src_digits[3:0]  == 4'h0) && !w_src_dp[0];
  assign w_z1 = w_z0 && (w_src_digits[7:4]  == 4'h0) && !w_src_dp[1];
  assign w_z2 = w_z1 && (w_src_digits[11:8] == 4'h0) && !w_src_dp[2];
  assign w_auto_blank = {1'b0, w_z2, w_z1, w_z0};
`else
  assign w_auto_blank = 4'b0000;
`endif

  assign w_cur_val   = r_act_digits[{r_slot, 2'b00} +: 4];
  assign w_cur_dp    = r_act_dp[r_slot];
  assign w_cur_blank = r_act_blank[r_slot];

  // Slot timebase: cnt runs 0..SCAN_DIV-1, slot advances on each rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 32'd0;
      r_slot <= 2'd0;
    end else if (w_last_cnt) begin
      r_cnt  <= 32'd0;
      r_slot <= r_slot + 2'd1;
    end else begin
      r_cnt  <= r_cnt + 32'd1;
    end
  end

  // Pending buffer takes every load; active buffer only changes at frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_digits <= 16'h0000;
      r_pend_dp     <= 4'b0000;
      r_pend_blank  <= 4'b0000;
      r_act_digits  <= 16'h0000;
      r_act_dp      <= 4'b0000;
      r_act_blank   <= 4'b0000;
    end else begin
      if (load) begin
        r_pend_digits <= digits;
        r_pend_dp     <= dp_mask;
        r_pend_blank  <= blank_mask;
      end
      if (w_wrap) begin
        r_act_digits <= w_src_digits;
        r_act_dp     <= w_src_dp;
        r_act_blank  <= w_src_blank | w_auto_blank;
      end
    end
  end

  // Next pin values from the current slot/phase and active buffer.
  always_comb begin
    w_dig_nxt = 4'b1111;
    w_seg_nxt = 8'hFF;
    if (w_phase == PH_ON && !w_cur_blank) begin
      w_dig_nxt = ~(4'b0001 << r_slot);
      w_seg_nxt = {~w_cur_dp, decode(w_cur_val)};
    end
  end

  // Register pins one cycle behind internal state; frame_done marks the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig        <= 4'b1111;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_dig        <= w_dig_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dig        = r_dig;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with SCAN_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
// Driver steps one clock at a time and queues the hand-derived pin values for
// that cycle; the monitor pops and compares on every falling edge.
// Expectations for LEADING_ZERO_BLANK_EN follow the same macro.
module tb_seven_seg_scanner;

  localparam logic [31:0] SD = 32'd8;
  localparam logic [31:0] BC = 32'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic [3:0]  blank_mask = 4'b0000;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  int          n_checks = 0;
  int          n_fail = 0;

  seven_seg_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .load       (load),
    .seg        (seg),
    .dig        (dig),
    .frame_done (frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d expectations still queued", exp_q.size());
    $fatal(1, "timeout");
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if ({dig, seg, frame_done} !== mon_e) begin
          n_fail++;
          $display("FAIL out[%0d] @%0t: got dig=%b seg=%h fd=%b, want dig=%b seg=%h fd=%b",
                   n_checks, $time, dig, seg, frame_done, mon_e[12:9], mon_e[8:1], mon_e[0]);
        end
      end
    end
  end

  // One clock; queue the pin values expected right after this edge.
  task automatic step(input logic [3:0] d, input logic [7:0] s, input logic fd);
    @(posedge clk);
    #1;
    exp_q.push_back({d, s, fd});
  endtask

  // One frame (or its first 'stop' cycles). segs = {slot3,slot2,slot1,slot0}
  // lit patterns, dark = slots expected fully off. Optional load at cycle load_at.
  task automatic run_frame(input logic [31:0] segs, input logic [3:0] dark,
                           input int stop, input int load_at,
                           input logic [15:0] ld_d, input logic [3:0] ld_dp,
                           input logic [3:0] ld_bl);
    int sl;
    int c;
    logic [3:0] ed;
    logic [7:0] es;
    for (int n = 0; n < stop; n++) begin
      if (n == load_at) begin
        load = 1'b1;
        digits = ld_d;
        dp_mask = ld_dp;
        blank_mask = ld_bl;
      end
      sl = n / 8;
      c  = n % 8;
      if (c < 2 || dark[sl]) begin
        ed = 4'hF;
        es = 8'hFF;
      end else begin
        ed = ~(4'b0001 << sl);
        es = segs[sl*8 +: 8];
      end
      step(ed, es, n == 31);
      load = 1'b0;
    end
  endtask

  // Stimulus
  initial begin
    // Reset state
    rst = 1'b1;
    step(4'hF, 8'hFF, 1'b0);
    rst = 1'b0;

    // A: idle scan of zeros
    run_frame(32'hC0C0C0C0, 4'b0000, 32, -1, 16'h0, 4'h0, 4'h0);
    // B: mid-frame load does not disturb the current frame
    run_frame(32'hC0C0C0C0, 4'b0000, 32, 10, 16'h9F21, 4'b0010, 4'b0000);
    // C: new values; load exactly on the wrap cycle
    run_frame(32'h908E24F9, 4'b0000, 32, 31, 16'h5555, 4'b0000, 4'b0000);
    // D: bypass load visible immediately; queue a blank mask
    run_frame(32'h92929292, 4'b0000, 32, 10, 16'h5555, 4'b0000, 4'b1010);
    // E: slots 1 and 3 dark
    run_frame(32'h92929292, 4'b1010, 32, -1, 16'h0, 4'h0, 4'h0);
    // F: load then reset during slot 2 ON phase
    run_frame(32'h92929292, 4'b1010, 20, 5, 16'h1234, 4'b0000, 4'b0000);
    rst = 1'b1;
    step(4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    // G: restart from slot 0 with reset buffers
    run_frame(32'hC0C0C0C0, 4'b0000, 32, -1, 16'h0, 4'h0, 4'h0);
    // H: pending buffer was cleared by reset
`ifdef LEADING_ZERO_BLANK_EN
    run_frame(32'hC0C0C0C0, 4'b0111, 32, 10, 16'h0500, 4'b0000, 4'b0000);
    // I: leading zeros of 0500 suppressed
    run_frame(32'hC092C0C0, 4'b0011, 32, 10, 16'h0500, 4'b0001, 4'b0000);
`else
    run_frame(32'hC0C0C0C0, 4'b0000, 32, 10, 16'h0500, 4'b0000, 4'b0000);
    run_frame(32'hC092C0C0, 4'b0000, 32, 10, 16'h0500, 4'b0001, 4'b0000);
`endif
    // J: dp on digit0 stops suppression
    run_frame(32'hC092C040, 4'b0000, 32, -1, 16'h0, 4'h0, 4'h0);

    // Drain the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Downstream display stage for the 4-digit button/counter logic. It takes four 4-bit digit values plus per-digit decimal-point and blank masks, and time-multiplexes them onto the shared active-low seg/dig pins of the common-anode 4-digit display. It adds an inter-digit blanking guard against ghosting and double-buffers input values so a frame never shows a mix of old and new values. It replaces the single-digit, single-position drive used by the current test logic.

Parameters:
SCAN_DIV, 32'd12500, clk cycles per digit slot (BLANK phase + ON phase); must be >= 2
BLANK_CYCLES, 32'd16, cycles at the start of each slot with all digits off; must be >= 1 and < SCAN_DIV

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
digits  input  16  digit values; [3:0]=digit0 (leftmost) ... [15:12]=digit3 (rightmost)
dp_mask  input  4  bit i=1 lights the decimal point of digit i
blank_mask  input  4  bit i=1 forces digit i fully dark
load  input  1  1-cycle strobe; capture digits/dp_mask/blank_mask into the pending buffer
seg  output  8  segment drive, active-low; [7]=dp, [6:0]=g..a
dig  output  4  digit select, active-low; [0]=leftmost (1110), [3]=rightmost (0111)
frame_done  output  1  1-cycle pulse on the last cycle of slot 3

Behaviour:
- Reset (rst=1 at posedge clk): slot=0, phase=BLANK, cycle counter=0, pending and active buffers=0 (digits 0000, dp 0, blank 0). Registered outputs: dig=4'b1111, seg=8'hFF, frame_done=0.
- Counter: cnt counts 0..SCAN_DIV-1 within a slot. At cnt==SCAN_DIV-1, cnt returns to 0 and slot advances 0->1->2->3->0 (wraps).
- Phase: BLANK while cnt < BLANK_CYCLES; ON otherwise.
- Outputs are registered with 1-cycle latency from internal state:
  - BLANK phase: dig=1111, seg=FF.
  - ON phase: dig selects the current slot (1110, 1101, 1011, 0111 for slots 0..3).
  - ON phase: seg = decode(active digit) with seg[7]=~dp. If blank_mask bit is set, seg=FF and dig=1111.
- Decode, seg[7:0] with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=D8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Buffering:
  - load writes the pending buffer; with multiple loads in a frame, the last one wins.
  - The active buffer copies pending on the frame-wrap cycle (slot 3, cnt==SCAN_DIV-1).
  - If load coincides with the wrap cycle, the load's input values go directly into active (bypass).
  - The active buffer never changes mid-frame.
- frame_done: high exactly one cycle, the cycle after the wrap decision (aligned with registered outputs), once per 4*SCAN_DIV cycles.
- Reset mid-frame: takes effect on the next edge. Outputs return to reset values the following cycle; pending loads are discarded.
- rst has priority over load on the same edge.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- When defined: while latching the active buffer, leading digits whose value is 0 are treated as blanked, scanning from digit0 toward digit2. Digit3 is never auto-blanked. A digit with its dp bit set stops suppression at that digit. Auto-blanking ORs with blank_mask.
- When undefined: zeros are always displayed as C0.

Test Plan:
1. SCAN_DIV=8, BLANK_CYCLES=2, release rst, no load -> dig sequence 1111 x2, 1110 x6, 1111 x2, 1101 x6 ... with seg=C0 in each ON phase; frame_done pulses every 32 cycles.
2. load digits=16'h9F21, dp_mask=4'b0010 mid-frame -> current frame unchanged; next frame shows 1 (F9), 2 with dp (24), F (8E), 9 (90) on digits 0..3.
3. load asserted exactly on the wrap cycle with digits=16'h5555 -> the frame starting next cycle shows 92 on all four digits.
4. blank_mask=4'b1010 -> slots 1 and 3 keep dig=1111, seg=FF for their full slot; slots 0 and 2 unaffected.
5. rst pulsed during slot 2 ON phase -> next registered outputs dig=1111, seg=FF; scan restarts at slot 0; pending load lost; display reads 0000.
6. With LEADING_ZERO_BLANK_EN, digits=16'h0500 (digit0=0, digit1=0, digit2=5, digit3=0) -> digits 0 and 1 dark, digit2 shows 92, digit3 shows C0. Same input with dp_mask=4'b0001 -> digit0 shows C0 with dp lit (40).
